// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM state type and default parameters for the hazard controller
package pipe_ctrl_pkg;
   typedef enum logic {RUN, MEM_WAIT} state_t;
   localparam int DEF_INST_ADDR_WIDTH    = 9;
   localparam int DEF_REGFILE_ADDR_WIDTH = 5;
   localparam int DEF_CNT_WIDTH          = 16;
   localparam int DEF_MEM_TIMEOUT        = 256;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   always_ff @(posedge clk) begin
      if (reset || clr) count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline stall/flush/redirect control with memory-wait FSM
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int INST_ADDR_WIDTH    = DEF_INST_ADDR_WIDTH,
   parameter int REGFILE_ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH,
   parameter int CNT_WIDTH          = DEF_CNT_WIDTH,
   parameter int MEM_TIMEOUT        = DEF_MEM_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          beq_mem,
   input  logic                          bneq_mem,
   input  logic                          zero_mem,
   input  logic [INST_ADDR_WIDTH-1:0]    branch_target_mem,
   input  logic                          mem_req_mem,
   input  logic                          mem_ready,
   input  logic                          mem_read_ex,
   input  logic                          WR_en_ex,
   input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_ex,
   input  logic [REGFILE_ADDR_WIDTH-1:0] rs_addr_id,
   input  logic [REGFILE_ADDR_WIDTH-1:0] rt_addr_id,
   input  logic                          rs_used_id,
   input  logic                          rt_used_id,
   input  logic                          cnt_clr,
   output logic                          pc_en,
   output logic                          if_id_en,
   output logic                          id_ex_en,
   output logic                          ex_mem_en,
   output logic                          mem_wb_en,
   output logic                          if_id_flush,
   output logic                          id_ex_flush,
   output logic                          ex_mem_flush,
   output logic                          mem_wb_flush,
   output logic                          pc_sel,
   output logic [INST_ADDR_WIDTH-1:0]    pc_target,
   output logic [CNT_WIDTH-1:0]          stall_cycles,
   output logic [CNT_WIDTH-1:0]          taken_branches,
   output logic                          mem_timeout_err
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
   state_t        state;
   logic [WW-1:0] wait_cnt;
   logic          taken, load_use, mem_stall, br, lu, run;
   assign taken     = (beq_mem & zero_mem) | (bneq_mem & ~zero_mem);
   assign load_use  = mem_read_ex & WR_en_ex & (WR_addr_ex != '0) &
                      ((rs_used_id & (rs_addr_id == WR_addr_ex)) | (rt_used_id & (rt_addr_id == WR_addr_ex)));
   assign mem_stall = mem_req_mem & ~mem_ready;
   // run: out of reset and not frozen by memory; br/lu resolve the remaining priority
   assign run = ~reset & ~mem_stall;
   assign br  = run & taken;
   assign lu  = run & ~taken & load_use;
   assign pc_en        = run & ~lu;
   assign if_id_en     = run & ~lu;
   assign id_ex_en     = run;
   assign ex_mem_en    = run;
   assign mem_wb_en    = ~reset;
   assign if_id_flush  = reset | br;
   assign id_ex_flush  = reset | br | lu;
   assign ex_mem_flush = reset | br;
   assign mem_wb_flush = reset | mem_stall;
   assign pc_sel       = br;
   assign pc_target    = branch_target_mem;
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= RUN;
         wait_cnt        <= '0;
         mem_timeout_err <= 1'b0;
      end else begin
         state <= mem_stall ? MEM_WAIT : RUN;
         if (state == RUN) wait_cnt <= '0;
         else if (mem_stall) begin
            if (wait_cnt == WAIT_LAST) mem_timeout_err <= 1'b1;
            else wait_cnt <= wait_cnt + 1'b1;
         end
      end
   end
   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk(clk), .reset(reset), .clr(cnt_clr), .inc(~pc_en), .count(stall_cycles)
   );
   sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
      .clk(clk), .reset(reset), .clr(cnt_clr), .inc(pc_sel), .count(taken_branches)
   );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table-driven and sequence checks of pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
   localparam int AW = 9, RW = 5, CW = 6, TO = 256;
   localparam int SAT = (1 << CW) - 1;
   // {pc_en,if_id_en,id_ex_en,ex_mem_en,mem_wb_en,if_id_fl,id_ex_fl,ex_mem_fl,mem_wb_fl,pc_sel}
   localparam logic [9:0] NORM = 10'b11111_0000_0;
   localparam logic [9:0] RST  = 10'b00000_1111_0;
   localparam logic [9:0] BR   = 10'b11111_1110_1;
   localparam logic [9:0] LU   = 10'b00111_0100_0;
   localparam logic [9:0] MS   = 10'b00001_0001_0;

   logic clk = 1'b0, reset = 1'b1, cnt_clr = 1'b0;
   logic beq_mem = 0, bneq_mem = 0, zero_mem = 0, mem_req_mem = 0, mem_ready = 0;
   logic mem_read_ex = 0, WR_en_ex = 0, rs_used_id = 0, rt_used_id = 0;
   logic [AW-1:0] branch_target_mem = '0, pc_target;
   logic [RW-1:0] WR_addr_ex = '0, rs_addr_id = '0, rt_addr_id = '0;
   logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel, mem_timeout_err;
   logic [CW-1:0] stall_cycles, taken_branches;

   pipe_hazard_ctrl #(.INST_ADDR_WIDTH(AW), .REGFILE_ADDR_WIDTH(RW), .CNT_WIDTH(CW), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .beq_mem(beq_mem), .bneq_mem(bneq_mem), .zero_mem(zero_mem),
      .branch_target_mem(branch_target_mem), .mem_req_mem(mem_req_mem), .mem_ready(mem_ready),
      .mem_read_ex(mem_read_ex), .WR_en_ex(WR_en_ex), .WR_addr_ex(WR_addr_ex),
      .rs_addr_id(rs_addr_id), .rt_addr_id(rt_addr_id), .rs_used_id(rs_used_id), .rt_used_id(rt_used_id),
      .cnt_clr(cnt_clr), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .pc_sel(pc_sel), .pc_target(pc_target),
      .stall_cycles(stall_cycles), .taken_branches(taken_branches), .mem_timeout_err(mem_timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic beq, bneq, zero, req, rdy, mrd, wren;
      logic [RW-1:0] wra, rsa, rta;
      logic rsu, rtu;
      logic [AW-1:0] tgt;
      logic [9:0] exp;
      string nm;
   } vec_t;

   int pass_cnt = 0, total = 0;
   int exp_stall = 0, exp_taken = 0;
   logic exp_err = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic step(input vec_t v, input logic rst, input logic clr);
      @(negedge clk);
      reset = rst;
      cnt_clr = clr;
      {beq_mem, bneq_mem, zero_mem, mem_req_mem, mem_ready, mem_read_ex, WR_en_ex} =
         {v.beq, v.bneq, v.zero, v.req, v.rdy, v.mrd, v.wren};
      {WR_addr_ex, rs_addr_id, rt_addr_id, rs_used_id, rt_used_id} = {v.wra, v.rsa, v.rta, v.rsu, v.rtu};
      branch_target_mem = v.tgt;
      #1;
      chk({v.nm, "_ctrl"}, 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                                if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel}), 32'(v.exp));
      chk({v.nm, "_target"}, 32'(pc_target), 32'(v.tgt));
      @(posedge clk);
      if (rst) exp_err = 1'b0;
      if (rst || clr) begin
         exp_stall = 0;
         exp_taken = 0;
      end else begin
         if (!v.exp[9] && exp_stall < SAT) exp_stall++;
         if (v.exp[0] && exp_taken < SAT) exp_taken++;
      end
      #1;
      chk({v.nm, "_stall_cnt"}, 32'(stall_cycles), 32'(exp_stall));
      chk({v.nm, "_taken_cnt"}, 32'(taken_branches), 32'(exp_taken));
      chk({v.nm, "_err"}, 32'(mem_timeout_err), 32'(exp_err));
   endtask

   initial begin
      vec_t tbl[14];
      vec_t idle, v;
      idle = '{0,0,0,0,1,0,0,5'd0,5'd0,5'd0,0,0,9'h000,NORM,"idle"};
      tbl[0]  = idle;
      tbl[1]  = '{1,0,1,0,1,0,0,5'd0,5'd0,5'd0,0,0,9'h07A,BR,"beq_taken"};
      tbl[2]  = '{1,0,0,0,1,0,0,5'd0,5'd0,5'd0,0,0,9'h155,NORM,"beq_not"};
      tbl[3]  = '{0,1,0,0,1,0,0,5'd0,5'd0,5'd0,0,0,9'h1FF,BR,"bneq_taken"};
      tbl[4]  = '{0,1,1,0,1,0,0,5'd0,5'd0,5'd0,0,0,9'h0AA,NORM,"bneq_not"};
      tbl[5]  = '{0,0,0,0,1,1,1,5'd3,5'd0,5'd3,0,1,9'h001,LU,"lu_rt"};
      tbl[6]  = '{0,0,0,0,1,1,1,5'd0,5'd0,5'd0,1,1,9'h002,NORM,"lu_r0"};
      tbl[7]  = '{0,0,0,0,1,1,1,5'd3,5'd3,5'd0,1,0,9'h003,LU,"lu_rs"};
      tbl[8]  = '{0,0,0,0,1,1,1,5'd3,5'd3,5'd3,0,0,9'h004,NORM,"lu_unused"};
      tbl[9]  = '{0,0,0,0,1,1,0,5'd3,5'd0,5'd3,0,1,9'h005,NORM,"lu_nowr"};
      tbl[10] = '{0,0,0,0,1,0,1,5'd3,5'd0,5'd3,0,1,9'h006,NORM,"lu_noload"};
      tbl[11] = '{1,0,1,0,1,1,1,5'd3,5'd0,5'd3,0,1,9'h0F0,BR,"br_over_lu"};
      tbl[12] = '{0,0,0,1,1,0,0,5'd0,5'd0,5'd0,0,0,9'h010,NORM,"mem_ready"};
      tbl[13] = '{0,0,0,0,1,1,1,5'd7,5'd7,5'd3,0,1,9'h011,NORM,"lu_mismatch"};

      v = tbl[1]; v.req = 1; v.rdy = 0; v.exp = RST; v.nm = "reset";
      step(v, 1, 0);
      step(v, 1, 0);
      for (int i = 0; i < 14; i++) step(tbl[i], 0, 0);

      v = idle; v.req = 1; v.rdy = 0; v.exp = MS; v.nm = "mem_stall";
      repeat (4) step(v, 0, 0);
      v.rdy = 1; v.exp = NORM; v.nm = "mem_done";
      step(v, 0, 0);

      v = tbl[1]; v.tgt = 9'h0C3; v.req = 1; v.rdy = 0; v.exp = MS; v.nm = "br_during_stall";
      repeat (2) step(v, 0, 0);
      v.rdy = 1; v.exp = BR; v.nm = "br_on_ready";
      step(v, 0, 0);
      step(idle, 0, 0);

      v = tbl[5]; v.nm = "clr_vs_inc";
      step(v, 0, 1);
      step(tbl[3], 0, 0);

      v = idle; v.req = 1; v.rdy = 0; v.exp = MS; v.nm = "timeout_wait";
      for (int i = 1; i <= TO + 1; i++) begin
         exp_err = (i == TO + 1);
         step(v, 0, 0);
      end
      chk("stall_saturated", 32'(stall_cycles), 32'(SAT));
      step(v, 0, 0);
      chk("stall_hold_sat", 32'(stall_cycles), 32'(SAT));
      v.rdy = 1; v.exp = NORM; v.nm = "err_sticky";
      repeat (2) step(v, 0, 0);

      v = idle; v.req = 1; v.rdy = 0; v.exp = MS; v.nm = "pre_reset_wait";
      repeat (3) step(v, 0, 0);
      v.exp = RST; v.nm = "reset_mid_wait";
      step(v, 1, 0);
      v = tbl[1]; v.req = 1; v.rdy = 1; v.nm = "post_reset_br";
      step(v, 0, 0);
      step(idle, 0, 0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter INST_ADDR_WIDTH, default 9, gives the PC/branch-target width.
REQ-002 Parameter REGFILE_ADDR_WIDTH, default 5, gives the register-address width.
REQ-003 Parameter CNT_WIDTH, default 16, gives the performance-counter width.
REQ-004 Parameter MEM_TIMEOUT, default 256, gives the maximum MEM_WAIT cycles before an error is flagged.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 beq_mem, bneq_mem, zero_mem  in  1 each  branch controls in the EX/MEM register output.
REQ-008 branch_target_mem  in  INST_ADDR_WIDTH  branch target in the EX/MEM register output.
REQ-009 mem_req_mem  in  1  the MEM-stage instruction accesses data memory (load or store).
REQ-010 mem_ready  in  1  data memory completes the current access this cycle.
REQ-011 mem_read_ex, WR_en_ex  in  1 each  the EX-stage instruction is a load / writes the register file.
REQ-012 WR_addr_ex  in  REGFILE_ADDR_WIDTH  EX-stage destination register.
REQ-013 rs_addr_id, rt_addr_id  in  REGFILE_ADDR_WIDTH each  ID-stage source registers.
REQ-014 rs_used_id, rt_used_id  in  1 each  the ID-stage instruction reads rs / rt.
REQ-015 cnt_clr  in  1  synchronous clear of both performance counters.
REQ-016 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables.
REQ-017 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1 each  pipeline register synchronous clears, which insert a bubble.
REQ-018 pc_sel  out  1  PC loads pc_target instead of PC+1.
REQ-019 pc_target  out  INST_ADDR_WIDTH  redirect address.
REQ-020 stall_cycles, taken_branches  out  CNT_WIDTH each  saturating performance counters.
REQ-021 mem_timeout_err  out  1  sticky memory-timeout error.

Function
REQ-022 Taken SHALL be (beq_mem & zero_mem) | (bneq_mem & ~zero_mem).
REQ-023 load_use SHALL be mem_read_ex & WR_en_ex & (WR_addr_ex != 0) & ((rs_used_id & rs_addr_id == WR_addr_ex) | (rt_used_id & rt_addr_id == WR_addr_ex)).
REQ-024 mem_stall SHALL be mem_req_mem & ~mem_ready.
REQ-025 The FSM SHALL have two states, RUN and MEM_WAIT; all control outputs are combinational from state and inputs, with no added latency.
REQ-026 Priority SHALL be mem_stall > taken > load_use > normal.
REQ-027 Normal operation: all enables 1, all flushes 0, pc_sel 0.
REQ-028 mem_stall, in either state: pc/if_id/id_ex/ex_mem enables 0, mem_wb_flush 1, other flushes 0, pc_sel 0; RUN moves to MEM_WAIT.
REQ-029 In MEM_WAIT with mem_ready 1: return to RUN and apply the RUN rules (taken / load_use / normal) in the same cycle.
REQ-030 Taken: all enables 1, pc_sel 1, pc_target = branch_target_mem, if_id/id_ex/ex_mem flush 1, mem_wb_flush 0; this gives a 3-bubble branch penalty.
REQ-031 load_use: pc_en 0, if_id_en 0, id_ex_flush 1, ex_mem/mem_wb enables 1; this gives a 1-cycle stall.
REQ-032 pc_target SHALL equal branch_target_mem at all times; it is qualified only by pc_sel.
REQ-033 The wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle.
REQ-034 When the wait counter reaches MEM_TIMEOUT-1 with mem_ready 0, mem_timeout_err SHALL set; the FSM stays in MEM_WAIT.
REQ-035 mem_timeout_err SHALL stay set until reset.
REQ-036 stall_cycles SHALL increment every cycle with pc_en 0, saturating at all-ones.
REQ-037 taken_branches SHALL increment every cycle with pc_sel 1, saturating at all-ones.
REQ-038 cnt_clr SHALL override increment; the counter reads 0 the next cycle.

Reset
REQ-039 While reset is 1: all enables 0, all flushes 1, pc_sel 0.
REQ-040 Reset SHALL set state RUN, the wait counter 0, both performance counters 0, and mem_timeout_err 0.
REQ-041 Reset SHALL take priority over every other input, including mid-MEM_WAIT; normal rules apply from the first cycle with reset 0.

Structure
REQ-042 Package pipe_ctrl_pkg SHALL hold the state enum (RUN, MEM_WAIT) and the default parameter constants.
REQ-043 One sub-module, sat_counter (parameterised width, clr, inc), SHALL be instantiated twice for the performance counters.

Verification
REQ-044 beq_mem=1, zero_mem=1, branch_target_mem=9'h07A, no stall -> pc_sel=1, pc_target=07A, three flushes 1 for one cycle, taken_branches +1.
REQ-045 Load to r3 in EX, ID reads r3 on rt -> exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; no stall when WR_addr_ex=0.
REQ-046 mem_req_mem=1, mem_ready low 4 cycles -> 4 freeze cycles with mem_wb_flush=1, stall_cycles +4, RUN on the 5th cycle.
REQ-047 Taken branch and mem_stall in the same cycle -> stall only; branch redirect in the cycle mem_ready rises.
REQ-048 mem_ready held 0 -> mem_timeout_err=1 after 256 MEM_WAIT cycles; stays 1 until reset.
REQ-049 Force counter to FFFF and continue stalling -> counter holds FFFF; reset mid-MEM_WAIT -> RUN, all counters 0.
